// File: rtl/button_conditioner_if.sv
// Signal bundle between the raw board inputs and the conditioned pulses/level
// that feed the frequency and duty-cycle counters.
interface button_conditioner_if;
  logic btn_up;
  logic btn_down;
  logic sw_opcion;
  logic up_pulse;
  logic down_pulse;
  logic opcion;
  logic mode_change;

  modport master (
    output btn_up, btn_down, sw_opcion,
    input  up_pulse, down_pulse, opcion, mode_change
  );

  modport slave (
    input  btn_up, btn_down, sw_opcion,
    output up_pulse, down_pulse, opcion, mode_change
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes and debounces the up/down buttons and mode switch, then turns
// button presses into single-cycle pulses with hold-to-auto-repeat.
module button_conditioner #(
  parameter int DEB_CYCLES    = 500000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int CNT_W         = 25
) (
  input  logic                clk,
  input  logic                rst,
  button_conditioner_if.slave io
);

  localparam int CH_UP   = 0;
  localparam int CH_DOWN = 1;
  localparam int CH_SW   = 2;

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT,
    LOCK
  } state_t;

  logic [2:0] raw;
  logic [2:0] db;
  logic [1:0] pulse;
  logic       opcion_reg;
  logic       mode_change_reg;

  assign raw[CH_UP]   = io.btn_up;
  assign raw[CH_DOWN] = io.btn_down;
  assign raw[CH_SW]   = io.sw_opcion;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic             sync1_reg;
      logic             sync2_reg;
      logic             db_reg;
      logic [CNT_W-1:0] cnt_reg;

      // The counter only advances while the synced input disagrees with the
      // accepted level, so any agreeing sample restarts the qualification.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          db_reg    <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == db_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            db_reg  <= sync2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign db[gi] = db_reg;
    end

    for (gi = 0; gi < 2; gi++) begin : g_fsm
      localparam int OTHER = 1 - gi;

      state_t           state_reg;
      state_t           state_next;
      logic [CNT_W-1:0] timer_reg;
      logic [CNT_W-1:0] timer_next;
      logic             pulse_reg;
      logic             pulse_next;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_reg <= IDLE;
          timer_reg <= '0;
          pulse_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          timer_reg <= timer_next;
          pulse_reg <= pulse_next;
        end
      end

      // Both buttons held overrides everything: the pair locks and stays
      // silent until this button is let go.
      always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        pulse_next = 1'b0;
        if (db[gi] && db[OTHER]) begin
          state_next = LOCK;
          timer_next = '0;
        end else begin
          case (state_reg)
            IDLE: begin
              if (db[gi]) begin
                state_next = HOLD;
                timer_next = '0;
                pulse_next = 1'b1;
              end
            end
            HOLD: begin
              if (!db[gi]) begin
                state_next = IDLE;
                timer_next = '0;
              end else if (timer_reg == HOLD_LAST) begin
                state_next = REPEAT;
                timer_next = '0;
                pulse_next = 1'b1;
              end else begin
                timer_next = timer_reg + 1'b1;
              end
            end
            REPEAT: begin
              if (!db[gi]) begin
                state_next = IDLE;
                timer_next = '0;
              end else if (timer_reg == REPEAT_LAST) begin
                timer_next = '0;
                pulse_next = 1'b1;
              end else begin
                timer_next = timer_reg + 1'b1;
              end
            end
            LOCK: begin
              if (!db[gi]) begin
                state_next = IDLE;
                timer_next = '0;
              end
            end
            default: begin
              state_next = IDLE;
              timer_next = '0;
            end
          endcase
        end
      end

      assign pulse[gi] = pulse_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcion_reg      <= 1'b0;
      mode_change_reg <= 1'b0;
    end else begin
      opcion_reg      <= db[CH_SW];
      mode_change_reg <= db[CH_SW] ^ opcion_reg;
    end
  end

  assign io.up_pulse    = pulse[CH_UP];
  assign io.down_pulse  = pulse[CH_DOWN];
  assign io.opcion      = opcion_reg;
  assign io.mode_change = mode_change_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized bench for button_conditioner with a timestamp-based reference
// model of debounce windows, press/hold/repeat timing and lockout.
module tb_button_conditioner;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;
  localparam int CW   = 8;

  logic clk;
  logic rst;
  logic rst_val;
  int   tests_run = 0;
  int   failed = 0;
  int   cyc = 0;

  // reference model state
  bit rh [3][16];
  bit mdb [3];
  bit m_op, m_mc, m_up, m_dn;
  bit locked [2];
  bit active [2];
  int press [2];

  logic [2:0] stim [$];
  int up_i [$];
  int dn_i [$];
  int mc_i [$];
  bit mc_op [$];

  button_conditioner_if bif ();

  button_conditioner #(
    .DEB_CYCLES   (DEB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .CNT_W        (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] dut_out();
    return {bif.up_pulse, bif.down_pulse, bif.opcion, bif.mode_change};
  endfunction

  function automatic logic [3:0] exp_out();
    return {m_up, m_dn, m_op, m_mc};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      mdb[c] = 1'b0;
      for (int k = 0; k < 16; k++) rh[c][k] = 1'b0;
    end
    for (int c = 0; c < 2; c++) begin
      locked[c] = 1'b0;
      active[c] = 1'b0;
      press[c]  = 0;
    end
    m_op = 1'b0; m_mc = 1'b0; m_up = 1'b0; m_dn = 1'b0;
  endtask

  // One clock edge: outputs come from the levels accepted before this edge,
  // and a level flips once DEB consecutive synced samples all disagree with it.
  task automatic model_edge(input logic [2:0] v);
    bit old_db [3];
    bit pl [2];
    bit all_diff;
    int k;
    cyc++;
    if (rst == 1'b0) begin
      model_reset();
    end else begin
      for (int c = 0; c < 3; c++) old_db[c] = mdb[c];
      m_mc = (old_db[2] != m_op);
      m_op = old_db[2];
      for (int c = 0; c < 2; c++) begin
        pl[c] = 1'b0;
        if (locked[c]) begin
          if (!old_db[c]) begin
            locked[c] = 1'b0;
            active[c] = 1'b0;
          end
        end else if (old_db[0] && old_db[1]) begin
          locked[c] = 1'b1;
          active[c] = 1'b0;
        end else if (!old_db[c]) begin
          active[c] = 1'b0;
        end else if (!active[c]) begin
          active[c] = 1'b1;
          press[c]  = cyc;
          pl[c]     = 1'b1;
        end else begin
          k = cyc - press[c];
          pl[c] = (k >= HOLD) && (((k - HOLD) % REP) == 0);
        end
      end
      m_up = pl[0];
      m_dn = pl[1];
      for (int c = 0; c < 3; c++) begin
        for (int j = 15; j > 0; j--) rh[c][j] = rh[c][j-1];
        rh[c][0] = v[c];
        all_diff = 1'b1;
        for (int j = 2; j <= DEB + 1; j++) if (rh[c][j] == mdb[c]) all_diff = 1'b0;
        if (all_diff) mdb[c] = ~mdb[c];
      end
    end
  endtask

  task automatic step(input logic [2:0] v);
    @(negedge clk);
    rst = rst_val;
    bif.btn_up    = v[0];
    bif.btn_down  = v[1];
    bif.sw_opcion = v[2];
    @(posedge clk);
    model_edge(v);
    #1;
  endtask

  task automatic push(input logic [2:0] v, input int n);
    for (int i = 0; i < n; i++) stim.push_back(v);
  endtask

  task automatic record(input int i);
    if (bif.up_pulse === 1'b1) up_i.push_back(i);
    if (bif.down_pulse === 1'b1) dn_i.push_back(i);
    if (bif.mode_change === 1'b1) begin
      mc_i.push_back(i);
      mc_op.push_back(bif.opcion);
    end
  endtask

  task automatic clear_rec();
    stim.delete(); up_i.delete(); dn_i.delete(); mc_i.delete(); mc_op.delete();
  endtask

  task automatic test_reset();
    rst_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(3'($urandom_range(0, 7)));
      tests_run++;
      if (dut_out() !== 4'b0000) begin
        failed++;
        $display("FAIL reset_hold i=%0d got=%b exp=0000", i, dut_out());
      end
    end
    rst_val = 1'b1;
    for (int i = 0; i < DEB + 4; i++) begin
      step(3'b000);
      tests_run++;
      if (dut_out() !== exp_out()) begin
        failed++;
        $display("FAIL reset_release i=%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
    end
  endtask

  task automatic test_glitch();
    int r;
    int first;
    clear_rec();
    push(3'b000, 3);
    push(3'b001, $urandom_range(1, DEB - 1));
    push(3'b000, 12);
    r = stim.size();
    push(3'b001, $urandom_range(DEB, DEB + 5));
    push(3'b000, 16);
    foreach (stim[i]) begin
      step(stim[i]);
      tests_run++;
      if (dut_out() !== exp_out()) begin
        failed++;
        $display("FAIL glitch_cycle i=%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
      record(i);
    end
    first = (up_i.size() > 0) ? up_i[0] - r : -1;
    tests_run++;
    if (up_i.size() != 1) begin
      failed++;
      $display("FAIL glitch_count got=%0d exp=1", up_i.size());
    end
    tests_run++;
    if (first != DEB + 2) begin
      failed++;
      $display("FAIL glitch_latency got=%0d exp=%0d", first, DEB + 2);
    end
  endtask

  task automatic test_repeat();
    int r;
    int h;
    int rel;
    int exp_cnt;
    bit gaps_ok;
    clear_rec();
    push(3'b000, 2);
    r = stim.size();
    h = $urandom_range(36, 44);
    push(3'b010, h);
    rel = r + h;
    push(3'b000, DEB + 8);
    foreach (stim[i]) begin
      step(stim[i]);
      tests_run++;
      if (dut_out() !== exp_out()) begin
        failed++;
        $display("FAIL repeat_cycle i=%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
      record(i);
    end
    exp_cnt = 2 + (h - 1 - HOLD) / REP;
    tests_run++;
    if (dn_i.size() != exp_cnt || up_i.size() != 0) begin
      failed++;
      $display("FAIL repeat_count got=%0d/%0d exp=%0d/0", dn_i.size(), up_i.size(), exp_cnt);
    end
    gaps_ok = (dn_i.size() >= 3) && (dn_i[0] - r == DEB + 2) && (dn_i[1] - dn_i[0] == HOLD);
    for (int j = 2; j < dn_i.size(); j++) if (dn_i[j] - dn_i[j-1] != REP) gaps_ok = 1'b0;
    tests_run++;
    if (!gaps_ok) begin
      failed++;
      $display("FAIL repeat_spacing got=%0d pulses exp=press,+%0d,then every %0d", dn_i.size(), HOLD, REP);
    end
    tests_run++;
    if (dn_i.size() > 0 && dn_i[dn_i.size()-1] > rel + DEB + 2) begin
      failed++;
      $display("FAIL repeat_stop got=%0d exp<=%0d", dn_i[dn_i.size()-1], rel + DEB + 2);
    end
  endtask

  task automatic test_bounce();
    int r;
    int ph;
    int first;
    clear_rec();
    push(3'b000, 2);
    ph = $urandom_range(0, 1);
    for (int i = 0; i < 20; i++) push((((i + ph) % 2) == 1) ? 3'b001 : 3'b000, 1);
    push(3'b000, 1);
    r = stim.size();
    push(3'b001, DEB + 4);
    push(3'b000, 16);
    foreach (stim[i]) begin
      step(stim[i]);
      tests_run++;
      if (dut_out() !== exp_out()) begin
        failed++;
        $display("FAIL bounce_cycle i=%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
      record(i);
    end
    first = (up_i.size() > 0) ? up_i[0] - r : -1;
    tests_run++;
    if (up_i.size() != 1 || first != DEB + 2) begin
      failed++;
      $display("FAIL bounce_pulse got=%0d@%0d exp=1@%0d", up_i.size(), first, DEB + 2);
    end
  endtask

  task automatic test_lock();
    int r;
    int first;
    clear_rec();
    push(3'b000, 2);
    push(3'b011, 30);
    push(3'b001, 20);
    push(3'b000, 12);
    r = stim.size();
    push(3'b001, DEB + 4);
    push(3'b000, 14);
    foreach (stim[i]) begin
      step(stim[i]);
      tests_run++;
      if (dut_out() !== exp_out()) begin
        failed++;
        $display("FAIL lock_cycle i=%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
      record(i);
    end
    tests_run++;
    if (dn_i.size() != 0) begin
      failed++;
      $display("FAIL lock_down_silent got=%0d exp=0", dn_i.size());
    end
    first = (up_i.size() > 0) ? up_i[0] - r : -1;
    tests_run++;
    if (up_i.size() != 1 || first != DEB + 2) begin
      failed++;
      $display("FAIL lock_repress got=%0d@%0d exp=1@%0d", up_i.size(), first, DEB + 2);
    end
  endtask

  task automatic test_mode();
    int s1;
    int s0;
    clear_rec();
    push(3'b000, 2);
    push(3'b100, 1);
    push(3'b000, 1);
    s1 = stim.size();
    push(3'b100, DEB + 12);
    push(3'b000, 1);
    push(3'b100, 1);
    s0 = stim.size();
    push(3'b000, DEB + 12);
    foreach (stim[i]) begin
      step(stim[i]);
      tests_run++;
      if (dut_out() !== exp_out()) begin
        failed++;
        $display("FAIL mode_cycle i=%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
      record(i);
    end
    tests_run++;
    if (mc_i.size() != 2) begin
      failed++;
      $display("FAIL mode_change_count got=%0d exp=2", mc_i.size());
    end else begin
      tests_run++;
      if (mc_i[0] - s1 != DEB + 2 || mc_op[0] !== 1'b1) begin
        failed++;
        $display("FAIL mode_rise got=%0d/op%0b exp=%0d/op1", mc_i[0] - s1, mc_op[0], DEB + 2);
      end
      tests_run++;
      if (mc_i[1] - s0 != DEB + 2 || mc_op[1] !== 1'b0) begin
        failed++;
        $display("FAIL mode_fall got=%0d/op%0b exp=%0d/op0", mc_i[1] - s0, mc_op[1], DEB + 2);
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    int found;
    int first;
    clear_rec();
    for (int i = 0; i < DEB + 6; i++) begin
      step(3'b100);
      tests_run++;
      if (dut_out() !== exp_out()) begin
        failed++;
        $display("FAIL midrst_pre i=%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
    end
    found = -1;
    for (int i = 0; i < 40 && found < 0; i++) begin
      step(3'b101);
      tests_run++;
      if (dut_out() !== exp_out()) begin
        failed++;
        $display("FAIL midrst_hold i=%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
      if (i >= DEB + 2 + HOLD && m_up) found = i;
    end
    tests_run++;
    if (found < 0) begin
      failed++;
      $display("FAIL midrst_reach got=none exp=repeat pulse within 40 cycles");
    end
    #2;
    rst = 1'b0;
    rst_val = 1'b0;
    #1;
    tests_run++;
    if (dut_out() !== 4'b0000) begin
      failed++;
      $display("FAIL midrst_async got=%b exp=0000", dut_out());
    end
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(3'b101);
      tests_run++;
      if (dut_out() !== exp_out()) begin
        failed++;
        $display("FAIL midrst_inreset i=%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
    end
    rst_val = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(3'b101);
      tests_run++;
      if (dut_out() !== exp_out()) begin
        failed++;
        $display("FAIL midrst_after i=%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
      record(i);
    end
    first = (up_i.size() > 0) ? up_i[0] : -1;
    tests_run++;
    if (first != DEB + 2) begin
      failed++;
      $display("FAIL midrst_repress got=%0d exp=%0d", first, DEB + 2);
    end
    for (int i = 0; i < 14; i++) begin
      step(3'b000);
      tests_run++;
      if (dut_out() !== exp_out()) begin
        failed++;
        $display("FAIL midrst_tail i=%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] v;
    int rem [3];
    v = 3'b000;
    rem = '{0, 0, 0};
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (rem[c] == 0) begin
          v[c] = ~v[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(25, 50) : $urandom_range(1, 8);
        end
        rem[c]--;
      end
      step(v);
      tests_run++;
      if (dut_out() !== exp_out()) begin
        failed++;
        $display("FAIL random_cycle i=%0d in=%b got=%b exp=%b", i, v, dut_out(), exp_out());
      end
      tests_run++;
      if ((bif.up_pulse & bif.down_pulse) !== 1'b0) begin
        failed++;
        $display("FAIL random_exclusive i=%0d got=11 exp=not both", i);
      end
    end
    for (int i = 0; i < 16; i++) begin
      step(3'b000);
      tests_run++;
      if (dut_out() !== exp_out()) begin
        failed++;
        $display("FAIL random_tail i=%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    rst_val = 1'b0;
    bif.btn_up = 1'b0;
    bif.btn_down = 1'b0;
    bif.sw_opcion = 1'b0;
    model_reset();
    test_reset();
    test_glitch();
    test_repeat();
    test_bounce();
    test_lock();
    test_mode();
    test_reset_mid_repeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
